// File: rtl/fake_netlist_bist_ctrl.sv
// ============================================================================
// Module   : fake_netlist_bist_ctrl
// Brief    : BIST driver for a combinational netlist. It applies a pattern
//            sequence to stim_o and compacts resp_i into a MISR signature.
//            Optional macro BIST_LFSR_PATTERN_EN selects LFSR patterns in
//            place of a binary count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fake_netlist_bist_ctrl #(
  parameter int               N_IN     = 3,
  parameter int               N_OUT    = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter int               NUM_PAT  = 2**N_IN,
  parameter logic [SIG_W-1:0] EXP_SIG  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [N_IN-1:0]  stim_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] sig_o
);

`ifdef BIST_LFSR_PATTERN_EN
  // The all-zero state is a lock-up state for the LFSR, so it is never applied.
  localparam int c_NPAT = (NUM_PAT > (2**N_IN) - 1) ? (2**N_IN) - 1 : NUM_PAT;

  function automatic logic [15:0] lfsr_taps(input int n);
    case (n)
      2:       lfsr_taps = 16'h0003;
      3:       lfsr_taps = 16'h0006;
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  localparam logic [N_IN-1:0] c_TAPS = N_IN'(lfsr_taps(N_IN));
`else
  localparam int c_NPAT = NUM_PAT;
`endif

  // One spare bit so the counter can never wrap inside a run.
  localparam int              c_KW    = $clog2(c_NPAT) + 1;
  localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_NPAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_KW-1:0]   k_q, k_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic              pass_q, pass_d;

  logic [N_IN-1:0]   w_pat_first;
  logic [N_IN-1:0]   w_pat_next;
  logic [SIG_W-1:0]  w_misr;

`ifdef BIST_LFSR_PATTERN_EN
  assign w_pat_first = '1;
  assign w_pat_next  = {stim_q[N_IN-2:0], ^(stim_q & c_TAPS)};
`else
  assign w_pat_first = '0;
  assign w_pat_next  = N_IN'(k_q + c_KW'(1));
`endif

  assign w_misr = {sig_q[SIG_W-2:0], 1'b0}
                ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                ^ SIG_W'(resp_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stim_q  <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    pass_d  = pass_q;

    if (abort_i) begin
      // Signature deliberately survives an abort for debug.
      state_d = S_IDLE;
      k_d     = '0;
      stim_d  = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_RUN;
            k_d     = '0;
            stim_d  = w_pat_first;
            sig_d   = '0;
            pass_d  = 1'b0;
          end
        end
        S_RUN: begin
          sig_d = w_misr;
          if (k_q == c_KLAST) begin
            state_d = S_DONE;
            pass_d  = (w_misr == EXP_SIG);
          end else begin
            k_d    = k_q + c_KW'(1);
            stim_d = w_pat_next;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign stim_o = stim_q;
  assign sig_o  = sig_q;
  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign pass_o = pass_q;

endmodule

`default_nettype wire
